// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at issue, captures CDB results, retires one entry per cycle in order.
// Commit/flush outputs are registered (one cycle after the head is ready); issue is dropped while out_full.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_issue_ena,
    input  logic [4:0]        in_issue_dest,
    input  logic              in_issue_is_branch,
    input  logic              in_issue_pred_taken,
    output logic [TAG_W-1:0]  out_free_tag,
    output logic              out_full,
    input  logic              in_cdb_ena,
    input  logic [TAG_W-1:0]  in_cdb_tag,
    input  logic [DATA_W-1:0] in_cdb_value,
    input  logic              in_cdb_taken,
    input  logic [DATA_W-1:0] in_cdb_target,
    input  logic [TAG_W-1:0]  in_query_tag1,
    input  logic [TAG_W-1:0]  in_query_tag2,
    output logic              out_query_ready1,
    output logic              out_query_ready2,
    output logic [DATA_W-1:0] out_query_value1,
    output logic [DATA_W-1:0] out_query_value2,
    output logic [4:0]        out_commit_reg,
    output logic [TAG_W-1:0]  out_commit_tag,
    output logic [DATA_W-1:0] out_commit_value,
    output logic              out_misbranch,
    output logic [DATA_W-1:0] out_redirect_pc
);
    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [4:0]        dest;
        logic [DATA_W-1:0] value;
        logic              is_branch;
        logic              pred_taken;
        logic              taken;
        logic [DATA_W-1:0] target;
    } entry_t;

    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE - 1);

    entry_t           rob [ROB_SIZE];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] count;
    logic             do_issue;
    logic             do_cdb;
    logic             do_commit;
    logic             mispredict;

    // Tag 0 means "no tag", so pointers skip it on wrap.
    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
        return (p == LAST_TAG) ? FIRST_TAG : p + FIRST_TAG;
    endfunction

    function automatic logic [DATA_W:0] lookup(
        input logic [TAG_W-1:0]  tag,
        input logic              ent_ready,
        input logic [DATA_W-1:0] ent_value,
        input logic              cdb_ena,
        input logic [TAG_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_value
    );
        if (tag == '0)                   return {1'b1, {DATA_W{1'b0}}};
        if (ent_ready)                   return {1'b1, ent_value};
        if (cdb_ena && cdb_tag == tag)   return {1'b1, cdb_value};
        return '0;
    endfunction

    assign out_full     = (count == LAST_TAG);
    assign out_free_tag = tail;

    assign do_issue   = ena && in_issue_ena && !out_full;
    assign do_cdb     = ena && in_cdb_ena && (in_cdb_tag != '0) && rob[in_cdb_tag].busy;
    assign do_commit  = ena && !out_misbranch && rob[head].busy && rob[head].ready;
    assign mispredict = do_commit && rob[head].is_branch && (rob[head].taken != rob[head].pred_taken);

    assign {out_query_ready1, out_query_value1} = lookup(in_query_tag1, rob[in_query_tag1].ready,
        rob[in_query_tag1].value, in_cdb_ena, in_cdb_tag, in_cdb_value);
    assign {out_query_ready2, out_query_value2} = lookup(in_query_tag2, rob[in_query_tag2].ready,
        rob[in_query_tag2].value, in_cdb_ena, in_cdb_tag, in_cdb_value);

    always_ff @(posedge clk) begin
        if (rst || out_misbranch) begin
            // Reset and the one-cycle misbranch flush both drain every in-flight entry.
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob[i].busy  <= 1'b0;
                rob[i].ready <= 1'b0;
            end
            head             <= FIRST_TAG;
            tail             <= FIRST_TAG;
            count            <= '0;
            out_commit_reg   <= '0;
            out_commit_tag   <= '0;
            out_commit_value <= '0;
            out_misbranch    <= 1'b0;
            out_redirect_pc  <= '0;
        end else begin
            out_commit_reg   <= '0;
            out_commit_tag   <= '0;
            out_commit_value <= '0;
            out_misbranch    <= mispredict;
            out_redirect_pc  <= mispredict ? rob[head].target : '0;

            if (do_cdb) begin
                rob[in_cdb_tag].ready  <= 1'b1;
                rob[in_cdb_tag].value  <= in_cdb_value;
                rob[in_cdb_tag].taken  <= in_cdb_taken;
                rob[in_cdb_tag].target <= in_cdb_target;
            end

            if (do_issue) begin
                rob[tail] <= '{busy: 1'b1, ready: 1'b0, dest: in_issue_dest, value: '0,
                               is_branch: in_issue_is_branch, pred_taken: in_issue_pred_taken,
                               taken: 1'b0, target: '0};
                tail <= next_ptr(tail);
            end

            if (do_commit) begin
                out_commit_reg   <= rob[head].dest;
                out_commit_tag   <= head;
                out_commit_value <= rob[head].value;
                rob[head].busy   <= 1'b0;
                rob[head].ready  <= 1'b0;
                head             <= next_ptr(head);
            end

            case ({do_issue, do_commit})
                2'b10:   count <= count + FIRST_TAG;
                2'b01:   count <= count - FIRST_TAG;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand sequences for full/flush/reset, and a random run vs a queue model.
module tb_reorder_buffer;
    logic        clk, rst, ena, iss, br, pred, full, cdb_ena, taken, qr1, qr2, mis;
    logic [4:0]  dest, creg;
    logic [3:0]  free_tag, cdb_tag, q1, q2, ctag;
    logic [31:0] cdb_val, tgt, qv1, qv2, cval, rpc;
    int total = 0;
    int bad = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_issue_ena(iss), .in_issue_dest(dest), .in_issue_is_branch(br), .in_issue_pred_taken(pred),
        .out_free_tag(free_tag), .out_full(full),
        .in_cdb_ena(cdb_ena), .in_cdb_tag(cdb_tag), .in_cdb_value(cdb_val), .in_cdb_taken(taken),
        .in_cdb_target(tgt),
        .in_query_tag1(q1), .in_query_tag2(q2),
        .out_query_ready1(qr1), .out_query_ready2(qr2), .out_query_value1(qv1), .out_query_value2(qv2),
        .out_commit_reg(creg), .out_commit_tag(ctag), .out_commit_value(cval),
        .out_misbranch(mis), .out_redirect_pc(rpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit iss; logic [4:0] dest; bit cdb; logic [3:0] ctag; logic [31:0] cval; logic [3:0] q;
        bit e_full; logic [3:0] e_free; bit e_qr; logic [31:0] e_qv;
        logic [4:0] e_creg; logic [3:0] e_ctag; logic [31:0] e_cval;
    } vec_t;
    vec_t vt[14];

    // Reference model: live entries in program order.
    typedef struct {
        logic [3:0] tag; logic [4:0] dest; bit rdy; logic [31:0] val;
        bit br; bit pred; bit tk; logic [31:0] tgt;
    } ment_t;
    ment_t       mq[$];
    int          m_tail;
    bit          m_flush;
    logic [4:0]  e_creg;
    logic [3:0]  e_ctag;
    logic [31:0] e_cval, e_rpc;
    bit          e_mis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss = 0; dest = 0; br = 0; pred = 0; cdb_ena = 0; cdb_tag = 0; cdb_val = 0;
        taken = 0; tgt = 0; q1 = 0; q2 = 0;
    endtask

    task automatic do_reset();
        idle(); ena = 1; rst = 1;
        tick();
        rst = 0;
    endtask

    function automatic logic [3:0] pick_tag();
        if (mq.size() == 0 || $urandom_range(0, 4) == 0) return 4'd0;
        return mq[$urandom_range(0, mq.size() - 1)].tag;
    endfunction

    function automatic void m_query(input logic [3:0] t, output bit r, output logic [31:0] v);
        r = 0; v = 0;
        if (t == 0) begin r = 1; return; end
        foreach (mq[k]) if (mq[k].tag == t && mq[k].rdy) begin r = 1; v = mq[k].val; return; end
        if (cdb_ena && cdb_tag == t) begin r = 1; v = cdb_val; end
    endfunction

    task automatic model_step();
        ment_t e;
        bit    was_full;
        if (rst || m_flush) begin
            mq.delete(); m_tail = 1; m_flush = 0;
            e_creg = 0; e_ctag = 0; e_cval = 0; e_mis = 0; e_rpc = 0;
        end else if (!ena) begin
            e_creg = 0; e_ctag = 0; e_mis = 0;
        end else begin
            was_full = (mq.size() == 15);
            e_creg = 0; e_ctag = 0; e_mis = 0;
            if (mq.size() > 0 && mq[0].rdy) begin
                e_creg = mq[0].dest; e_ctag = mq[0].tag; e_cval = mq[0].val;
                if (mq[0].br && mq[0].tk != mq[0].pred) begin
                    e_mis = 1; e_rpc = mq[0].tgt; m_flush = 1;
                end
                void'(mq.pop_front());
            end
            if (cdb_ena && cdb_tag != 0)
                foreach (mq[k]) if (mq[k].tag == cdb_tag) begin
                    mq[k].rdy = 1; mq[k].val = cdb_val; mq[k].tk = taken; mq[k].tgt = tgt;
                end
            if (iss && !was_full) begin
                e.tag = 4'(m_tail); e.dest = dest; e.rdy = 0; e.val = 0;
                e.br = br; e.pred = pred; e.tk = 0; e.tgt = 0;
                mq.push_back(e);
                m_tail = (m_tail == 15) ? 1 : m_tail + 1;
            end
        end
    endtask

    initial begin
        bit          er;
        logic [31:0] ev;
        // iss,dest, cdb,ctag,cval, q | full,free,qr,qv | creg,ctag,cval (commit visible after the edge)
        vt[0]  = '{1, 5'd5, 0, 4'd0, 32'h0,        4'd0, 0, 4'd1, 1, 32'h0,        5'd0, 4'd0, 32'h0};
        vt[1]  = '{0, 5'd0, 1, 4'd1, 32'hDEADBEEF, 4'd1, 0, 4'd2, 1, 32'hDEADBEEF, 5'd0, 4'd0, 32'h0};
        vt[2]  = '{0, 5'd0, 0, 4'd0, 32'h0,        4'd1, 0, 4'd2, 1, 32'hDEADBEEF, 5'd5, 4'd1, 32'hDEADBEEF};
        vt[3]  = '{0, 5'd0, 0, 4'd0, 32'h0,        4'd0, 0, 4'd2, 1, 32'h0,        5'd0, 4'd0, 32'h0};
        vt[4]  = '{1, 5'd7, 0, 4'd0, 32'h0,        4'd2, 0, 4'd2, 0, 32'h0,        5'd0, 4'd0, 32'h0};
        vt[5]  = '{1, 5'd8, 0, 4'd0, 32'h0,        4'd2, 0, 4'd3, 0, 32'h0,        5'd0, 4'd0, 32'h0};
        vt[6]  = '{1, 5'd9, 0, 4'd0, 32'h0,        4'd0, 0, 4'd4, 1, 32'h0,        5'd0, 4'd0, 32'h0};
        vt[7]  = '{0, 5'd0, 1, 4'd4, 32'h44,       4'd4, 0, 4'd5, 1, 32'h44,       5'd0, 4'd0, 32'h0};
        vt[8]  = '{0, 5'd0, 1, 4'd3, 32'h33,       4'd4, 0, 4'd5, 1, 32'h44,       5'd0, 4'd0, 32'h0};
        vt[9]  = '{0, 5'd0, 1, 4'd2, 32'h22,       4'd3, 0, 4'd5, 1, 32'h33,       5'd0, 4'd0, 32'h0};
        vt[10] = '{0, 5'd0, 0, 4'd0, 32'h0,        4'd2, 0, 4'd5, 1, 32'h22,       5'd7, 4'd2, 32'h22};
        vt[11] = '{0, 5'd0, 0, 4'd0, 32'h0,        4'd3, 0, 4'd5, 1, 32'h33,       5'd8, 4'd3, 32'h33};
        vt[12] = '{0, 5'd0, 0, 4'd0, 32'h0,        4'd4, 0, 4'd5, 1, 32'h44,       5'd9, 4'd4, 32'h44};
        vt[13] = '{0, 5'd0, 0, 4'd0, 32'h0,        4'd0, 0, 4'd5, 1, 32'h0,        5'd0, 4'd0, 32'h0};

        idle(); ena = 1; rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_creg", creg, 0); chk("rst_ctag", ctag, 0); chk("rst_cval", cval, 0);
        chk("rst_mis", mis, 0); chk("rst_rpc", rpc, 0); chk("rst_full", full, 0); chk("rst_free", free_tag, 1);

        for (int i = 0; i < 14; i++) begin
            iss = vt[i].iss; dest = vt[i].dest; cdb_ena = vt[i].cdb; cdb_tag = vt[i].ctag;
            cdb_val = vt[i].cval; q1 = vt[i].q; q2 = vt[i].q;
            #1;
            chk($sformatf("tbl%0d_full", i), full, vt[i].e_full);
            chk($sformatf("tbl%0d_free", i), free_tag, vt[i].e_free);
            chk($sformatf("tbl%0d_qr1", i), qr1, vt[i].e_qr);
            chk($sformatf("tbl%0d_qr2", i), qr2, vt[i].e_qr);
            if (vt[i].e_qr) begin
                chk($sformatf("tbl%0d_qv1", i), qv1, vt[i].e_qv);
                chk($sformatf("tbl%0d_qv2", i), qv2, vt[i].e_qv);
            end
            tick();
            chk($sformatf("tbl%0d_creg", i), creg, vt[i].e_creg);
            chk($sformatf("tbl%0d_ctag", i), ctag, vt[i].e_ctag);
            if (vt[i].e_ctag != 0) chk($sformatf("tbl%0d_cval", i), cval, vt[i].e_cval);
            chk($sformatf("tbl%0d_mis", i), mis, 0);
        end

        // Fill to capacity, wrap the tail, drop issue while full even with a commit.
        do_reset();
        for (int i = 0; i < 15; i++) begin iss = 1; dest = 5'(i + 1); tick(); end
        iss = 0; #1;
        chk("fill_full", full, 1); chk("fill_free_wrap", free_tag, 1);
        iss = 1; dest = 20; tick(); iss = 0; #1;
        chk("drop_full", full, 1); chk("drop_free", free_tag, 1);
        cdb_ena = 1; cdb_tag = 1; cdb_val = 32'hA1; tick(); cdb_ena = 0;
        iss = 1; dest = 21; tick(); iss = 0;
        chk("wrap_ctag", ctag, 1); chk("wrap_creg", creg, 1); chk("wrap_cval", cval, 32'hA1);
        #1;
        chk("wrap_full", full, 0); chk("wrap_free", free_tag, 1);
        iss = 1; dest = 22; tick(); iss = 0; #1;
        chk("refill_full", full, 1); chk("refill_free", free_tag, 2);

        // Mispredicted branch flushes younger entries for exactly one cycle.
        do_reset();
        iss = 1; dest = 0; br = 1; pred = 0; tick();
        br = 0; dest = 3; tick(); dest = 4; tick(); iss = 0;
        cdb_ena = 1; cdb_tag = 1; taken = 1; tgt = 32'h100; tick(); cdb_ena = 0; taken = 0;
        tick();
        chk("mis_pulse", mis, 1); chk("mis_rpc", rpc, 32'h100); chk("mis_ctag", ctag, 1); chk("mis_creg", creg, 0);
        cdb_ena = 1; cdb_tag = 2; cdb_val = 32'h55; iss = 1; dest = 6; tick(); idle();
        chk("flush_mis", mis, 0); chk("flush_ctag", ctag, 0);
        #1;
        chk("flush_full", full, 0); chk("flush_free", free_tag, 1);
        cdb_ena = 1; cdb_tag = 2; cdb_val = 32'h66; tick(); cdb_ena = 0; q1 = 2; #1;
        chk("stale_cdb_qr1", qr1, 0); chk("stale_cdb_free", free_tag, 1);

        // ena low holds state and blanks commit; reset mid-stream with ena low.
        do_reset();
        for (int i = 0; i < 6; i++) begin iss = 1; dest = 5'(10 + i); tick(); end
        iss = 0; cdb_ena = 1; cdb_tag = 1; cdb_val = 32'h11; tick(); cdb_ena = 0;
        ena = 0; tick();
        chk("hold_ctag", ctag, 0); chk("hold_creg", creg, 0);
        #1; chk("hold_free", free_tag, 7);
        rst = 1; tick(); rst = 0; ena = 1;
        chk("mrst_creg", creg, 0); chk("mrst_ctag", ctag, 0); chk("mrst_cval", cval, 0);
        chk("mrst_mis", mis, 0); chk("mrst_rpc", rpc, 0);
        #1; chk("mrst_full", full, 0); chk("mrst_free", free_tag, 1);
        tick(); chk("mrst_nocommit", ctag, 0);

        // Random traffic against the queue model.
        idle(); ena = 1; rst = 1; model_step(); tick(); rst = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            ena = ($urandom_range(0, 9) != 0);
            iss = ($urandom_range(0, 9) < 6); dest = 5'($urandom_range(0, 31));
            br = ($urandom_range(0, 7) == 0); pred = 1'($urandom_range(0, 1));
            cdb_ena = 1'($urandom_range(0, 1));
            cdb_tag = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : pick_tag();
            cdb_val = $urandom; taken = 1'($urandom_range(0, 1)); tgt = $urandom;
            q1 = pick_tag(); q2 = pick_tag();
            #1;
            chk("rnd_full", full, mq.size() == 15);
            chk("rnd_free", free_tag, m_tail);
            m_query(q1, er, ev);
            chk("rnd_qr1", qr1, er); if (er) chk("rnd_qv1", qv1, ev);
            m_query(q2, er, ev);
            chk("rnd_qr2", qr2, er); if (er) chk("rnd_qv2", qv2, ev);
            model_step();
            tick();
            chk("rnd_creg", creg, e_creg); chk("rnd_ctag", ctag, e_ctag); chk("rnd_mis", mis, e_mis);
            if (e_ctag != 0) chk("rnd_cval", cval, e_cval);
            if (e_mis) chk("rnd_rpc", rpc, e_rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer between decoder/issue and the architectural register file.
- Allocates ROB tags at issue and captures results from the common data bus (CDB).
- Answers operand-tag queries, with a same-cycle CDB bypass.
- Retires one entry per cycle in program order: drives the register file's commit index/tag/value inputs, and raises the misbranch flush that clears all register-file rename state.

Parameters:
ROB_SIZE, 16, number of tag codes; tag 0 is reserved as "no tag", so entries 1..ROB_SIZE-1 are usable (15 by default).
TAG_W, 4, tag width; log2(ROB_SIZE).
DATA_W, 32, data/PC width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
ena  input  1  global enable; when low, all state holds.
in_issue_ena  input  1  allocate one entry this cycle.
in_issue_dest  input  5  destination register; 0 means no writeback.
in_issue_is_branch  input  1  entry is a conditional branch.
in_issue_pred_taken  input  1  predicted direction.
out_free_tag  output  TAG_W  tag that an issue this cycle receives (the tail).
out_full  output  1  no free entry; issue is ignored.
in_cdb_ena  input  1  CDB result valid.
in_cdb_tag  input  TAG_W  producing entry.
in_cdb_value  input  DATA_W  result value.
in_cdb_taken  input  1  resolved branch direction.
in_cdb_target  input  DATA_W  correct next PC if mispredicted.
in_query_tag1, in_query_tag2  input  TAG_W  operand tags from register-file lookup.
out_query_ready1, out_query_ready2  output  1  value available (combinational).
out_query_value1, out_query_value2  output  DATA_W  value (combinational).
out_commit_reg  output  5  register index to write; 0 when no commit.
out_commit_tag  output  TAG_W  tag of retiring entry.
out_commit_value  output  DATA_W  retiring value.
out_misbranch  output  1  one-cycle flush pulse.
out_redirect_pc  output  DATA_W  fetch redirect target, valid with out_misbranch.

Behaviour:
- Per-entry state: busy, ready, dest, value, is_branch, pred_taken, taken, target.
- Pointers head/tail cycle over 1..ROB_SIZE-1; after ROB_SIZE-1 they wrap to 1 and never take the value 0.
- Occupancy counter runs 0..ROB_SIZE-1. out_full = (count == ROB_SIZE-1). out_free_tag = tail.
- Priority order is rst > flush > ena-gated updates.
- Reset: head = tail = 1, count = 0, all busy/ready cleared, every output register 0.
- Issue (ena && in_issue_ena && !out_full): entry[tail] becomes busy, not ready, with fields loaded; tail advances.
  - While full, issue is dropped even if a commit happens the same cycle.
- CDB write (ena && in_cdb_ena && entry busy): store value/taken/target and set ready. A CDB write to a non-busy tag or to tag 0 is ignored.
- Commit: when ena, head entry busy and ready, and no flush pending, retire it at the clock edge.
  - Outputs are registered; visible the cycle after the edge at which the entry is ready.
  - out_commit_reg = dest, out_commit_tag = head, out_commit_value = value.
  - Clear busy, advance head, decrement count.
  - Issue and commit in the same cycle leave count unchanged.
  - With no commit, out_commit_reg = 0 and out_commit_tag = 0; value is don't-care. A write to reg 0 is harmless downstream.
- Misprediction: a committing branch with taken != pred_taken commits normally and also registers out_misbranch = 1 and out_redirect_pc = target.
  - Next cycle, while out_misbranch is high, all entries are cleared, head = tail = 1, count = 0, and issue/CDB/commit are ignored.
  - out_misbranch drops the following cycle. The flush is exactly one cycle.
- Query (combinational): tag 0 gives ready = 1, value = 0.
  - Otherwise, if entry ready, return the stored value.
  - Otherwise, if in_cdb_ena and in_cdb_tag matches, bypass in_cdb_value with ready = 1.
  - Otherwise ready = 0.
- ena low: no state change. Commit outputs are forced to reg 0 / tag 0; out_misbranch is forced to 0.

Test Plan:
- After rst, issue dest=5 (tag 1); CDB tag 1 value 0xDEADBEEF -> next cycle out_commit_reg=5, tag=1, value=0xDEADBEEF; count returns to 0.
- Issue 15 entries -> out_full=1, 16th issue ignored, out_free_tag stays 1 (wrapped); commit one -> out_full=0, next issue gets tag 1.
- Complete tags 3, then 2, then 1 out of order -> commits appear in order 1, 2, 3 on consecutive cycles.
- Query tag 4 (busy, not ready) in the same cycle as CDB tag 4 value 0x77 -> out_query_ready1=1, value 0x77 combinationally; query tag 0 -> ready=1, value 0.
- Branch tag 1 pred_taken=0, younger tags 2-3 issued, CDB taken=1, target 0x100 -> out_misbranch=1 with out_redirect_pc=0x100 for one cycle; next cycle count=0, out_free_tag=1; a later CDB to tag 2 is ignored.
- rst asserted mid-stream with 6 entries live and ena low -> next cycle all outputs 0, out_full=0, out_free_tag=1.
